// File: rtl/credit_link_pkg.sv
// Shared types for the credit-flow-controlled internode link.
package credit_link_pkg;

  localparam int unsigned FLIT_SIZE = 82;

  typedef logic [FLIT_SIZE-1:0] flit_t;

  // Serial word carried by the forward flight pipe; shared with router/node wrappers.
  typedef struct packed {
    logic  valid;
    flit_t flit;
  } serial_word_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/credit_link_delay_pipe.sv
// Valid-tagged shift register modelling a fixed flight latency; MSB of each word is its valid bit.
module delay_pipe
  import credit_link_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Next stage contents: new word enters stage 1, everything else moves one stage on.
  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/credit_link.sv
// One direction of an internode channel: credit-gated TX, forward flight pipe,
// receive FIFO, and a credit return pipe of equal latency.
module credit_link
  import credit_link_pkg::*;
#(
  parameter int unsigned FLIT_SIZE   = credit_link_pkg::FLIT_SIZE,
  parameter int unsigned LINK_DELAY  = 50,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CREDIT_INIT = DEPTH,
  parameter int unsigned CNT_W       = $clog2(max_u(DEPTH, CREDIT_INIT) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [FLIT_SIZE-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [FLIT_SIZE-1:0] rx_data,
  input  logic                 rx_ready,
  output logic [CNT_W-1:0]     credit_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic                 err_overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FWD_W = FLIT_SIZE + 1;

  logic [CNT_W-1:0]     credit_q, credit_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 err_q, err_d;
  logic [FLIT_SIZE-1:0] mem_q [DEPTH];
  logic [FLIT_SIZE-1:0] mem_d [DEPTH];

  logic                 accept;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 arr_valid;
  logic [FLIT_SIZE-1:0] arr_data;
  logic                 credit_arrive;
  logic [FWD_W-1:0]     fwd_in;
  logic [FWD_W-1:0]     fwd_out;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and status decode from registered state only.
  assign tx_ready     = (credit_q != '0);
  assign rx_valid     = (count_q != '0);
  assign rx_data      = mem_q[rd_ptr_q];
  assign credit_count = credit_q;
  assign rx_count     = count_q;
  assign err_overflow = err_q;

  assign accept    = tx_valid & tx_ready;
  assign pop       = rx_valid & rx_ready;
  assign fwd_in    = {accept, tx_data};
  assign arr_valid = fwd_out[FWD_W-1];
  assign arr_data  = fwd_out[FLIT_SIZE-1:0];
  assign full      = (count_q == CNT_W'(DEPTH));
  // A pop frees the head slot in the same cycle, so a full buffer still takes the arrival.
  assign wr_en     = arr_valid & (~full | pop);

  delay_pipe #(
    .WIDTH  (FWD_W),
    .STAGES (LINK_DELAY)
  ) u_fwd_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (fwd_in),
    .dout (fwd_out)
  );

  delay_pipe #(
    .WIDTH  (1),
    .STAGES (LINK_DELAY)
  ) u_credit_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pop),
    .dout (credit_arrive)
  );

  // Next-state for credits, FIFO pointers/occupancy/storage and the sticky overflow flag.
  always_comb begin
    credit_d = credit_q - CNT_W'(accept) + CNT_W'(credit_arrive);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    err_d    = err_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = arr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (arr_valid & full & ~pop) begin
      err_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CNT_W'(CREDIT_INIT);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Buffer storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
